// File: rtl/ruta_datos_multiciclo_if.sv
// rtl/ruta_datos_multiciclo_if.sv - data memory request/ready bus for the multi-cycle datapath
//
// Purpose: groups the data memory handshake into one bundle.
//   master (datapath): drives dmem_req, dmem_we, dmem_addr, dmem_wdata;
//                      samples dmem_rdata, dmem_ready.
//   slave  (memory)  : the mirror image.
// A request is held stable by the master until the slave raises dmem_ready;
// dmem_ready completes the transfer in the same cycle.
interface ruta_datos_multiciclo_if #(
  parameter int DATA_W = 64
);
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ready;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/ruta_datos_multiciclo.sv
// rtl/ruta_datos_multiciclo.sv - multi-cycle LEGv8 datapath with FETCH/DECODE/EXEC/MEM/WB sequencing
//
// Purpose: executes one instruction every 4 cycles (non-memory) or 5 + wait
// cycles (loads/stores). Control comes from an external control unit that
// decodes opcode; its outputs are latched in DECODE and only the latched copy
// is used afterwards.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   instr, imem_addr    external instruction memory (combinational read at pc)
//   bus_*, beq, bne     control unit outputs, valid while in DECODE
//   dmem                data memory request/ready bus (master side)
//   opcode              IR[31:21] towards the control unit
//   pc, state           architectural PC and FSM state (FETCH=0 .. WB=4)
//
// Optional: define RUTA_PERF_CNT_EN to add cycle_count, instr_count and
// stall_count outputs (all 32-bit, cleared by rst, wrapping).
module ruta_datos_multiciclo #(
  parameter int                 DATA_W   = 64,
  parameter int                 NREGS    = 32,
  parameter logic [DATA_W-1:0]  PC_RESET = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               instr,
  output logic [DATA_W-1:0]         imem_addr,
  input  logic                      bus_reg2loc,
  input  logic [1:0]                bus_seu,
  input  logic                      bus_aluSrc,
  input  logic [2:0]                bus_aluOp,
  input  logic                      bus_memWr,
  input  logic                      bus_memToReg,
  input  logic                      bus_regWr,
  input  logic                      beq,
  input  logic                      bne,
  ruta_datos_multiciclo_if.master   dmem,
  output logic [10:0]               opcode,
  output logic [DATA_W-1:0]         pc,
  output logic [2:0]                state
`ifdef RUTA_PERF_CNT_EN
  ,
  output logic [31:0]               cycle_count,
  output logic [31:0]               instr_count,
  output logic [31:0]               stall_count
`endif
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] pc_q;
  logic [31:0]       ir_q;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] a_q, b_q, imm_q, aluout_q, mdr_q;
  logic              z_q;

  // Latched control word
  logic              ctrl_alusrc_q;
  logic [2:0]        ctrl_aluop_q;
  logic              ctrl_memwr_q;
  logic              ctrl_memtoreg_q;
  logic              ctrl_regwr_q;
  logic              ctrl_beq_q;
  logic              ctrl_bne_q;

  logic [4:0]        ra_idx, rb_idx;
  logic [DATA_W-1:0] ra_val, rb_val, imm_val;
  logic [DATA_W-1:0] alu_b, alu_y;
  logic              wr_en, take_branch;

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign opcode    = ir_q[31:21];
  assign state     = state_q;

  // Register read ports: the top index is XZR and anything beyond the file is zero.
  assign ra_idx = ir_q[9:5];
  assign rb_idx = bus_reg2loc ? ir_q[4:0] : ir_q[20:16];
  assign ra_val = (32'(ra_idx) < NREGS - 1) ? regs_q[ra_idx] : '0;
  assign rb_val = (32'(rb_idx) < NREGS - 1) ? regs_q[rb_idx] : '0;

  // Immediate formats: I (zero-extended imm12), D (addr9), B (imm26), CB (imm19).
  always_comb begin
    imm_val = '0;
    case (bus_seu)
      2'b00: imm_val = {{(DATA_W-12){1'b0}}, ir_q[21:10]};
      2'b01: imm_val = {{(DATA_W-9){ir_q[20]}}, ir_q[20:12]};
      2'b10: imm_val = {{(DATA_W-28){ir_q[25]}}, ir_q[25:0], 2'b00};
      default: imm_val = {{(DATA_W-21){ir_q[23]}}, ir_q[23:5], 2'b00};
    endcase
  end

  always_comb begin
    alu_b = ctrl_alusrc_q ? imm_q : b_q;
    alu_y = '0;
    case (ctrl_aluop_q)
      3'b000:  alu_y = a_q & alu_b;
      3'b001:  alu_y = a_q | alu_b;
      3'b010:  alu_y = a_q + alu_b;
      3'b110:  alu_y = a_q - alu_b;
      3'b111:  alu_y = alu_b;
      default: alu_y = '0;
    endcase
  end

  // Writes to XZR or past the register file are dropped.
  assign wr_en       = ctrl_regwr_q && (32'(ir_q[4:0]) < NREGS - 1);
  assign take_branch = (ctrl_beq_q & z_q) | (ctrl_bne_q & ~z_q);

  // Next state and data memory outputs; the bus is idle (all zero) outside MEM.
  always_comb begin
    state_d          = state_q;
    dmem.dmem_req    = 1'b0;
    dmem.dmem_we     = 1'b0;
    dmem.dmem_addr   = '0;
    dmem.dmem_wdata  = '0;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: state_d = EXEC;
      EXEC:   state_d = (ctrl_memwr_q | ctrl_memtoreg_q) ? MEM : WB;
      MEM: begin
        dmem.dmem_req   = 1'b1;
        dmem.dmem_we    = ctrl_memwr_q;
        dmem.dmem_addr  = aluout_q;
        dmem.dmem_wdata = b_q;
        if (dmem.dmem_ready) state_d = WB;
      end
      WB:      state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= FETCH;
      pc_q            <= PC_RESET;
      ir_q            <= '0;
      a_q             <= '0;
      b_q             <= '0;
      imm_q           <= '0;
      aluout_q        <= '0;
      mdr_q           <= '0;
      z_q             <= 1'b0;
      ctrl_alusrc_q   <= 1'b0;
      ctrl_aluop_q    <= '0;
      ctrl_memwr_q    <= 1'b0;
      ctrl_memtoreg_q <= 1'b0;
      ctrl_regwr_q    <= 1'b0;
      ctrl_beq_q      <= 1'b0;
      ctrl_bne_q      <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        FETCH: ir_q <= instr;
        DECODE: begin
          a_q             <= ra_val;
          b_q             <= rb_val;
          imm_q           <= imm_val;
          ctrl_alusrc_q   <= bus_aluSrc;
          ctrl_aluop_q    <= bus_aluOp;
          ctrl_memwr_q    <= bus_memWr;
          ctrl_memtoreg_q <= bus_memToReg;
          ctrl_regwr_q    <= bus_regWr;
          ctrl_beq_q      <= beq;
          ctrl_bne_q      <= bne;
        end
        EXEC: begin
          aluout_q <= alu_y;
          z_q      <= (alu_y == '0);
        end
        MEM: begin
          // A store wins when both memWr and memToReg are set, so MDR keeps its value.
          if (dmem.dmem_ready && ctrl_memtoreg_q && !ctrl_memwr_q) mdr_q <= dmem.dmem_rdata;
        end
        WB: begin
          if (wr_en) regs_q[ir_q[4:0]] <= ctrl_memtoreg_q ? mdr_q : aluout_q;
          pc_q <= take_branch ? pc_q + imm_q : pc_q + DATA_W'(4);
        end
        default: ;
      endcase
    end
  end

`ifdef RUTA_PERF_CNT_EN
  logic [31:0] cycle_q, instr_q, stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= '0;
      instr_q <= '0;
      stall_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (state_q == WB) instr_q <= instr_q + 32'd1;
      if (state_q == MEM && !dmem.dmem_ready) stall_q <= stall_q + 32'd1;
    end
  end

  assign cycle_count = cycle_q;
  assign instr_count = instr_q;
  assign stall_count = stall_q;
`endif

endmodule

// File: doc/ruta_datos_multiciclo.md
Name: ruta_datos_multiciclo

Overview:
Parametrised multi-cycle LEGv8 datapath and successor to the single-cycle datapath. A five-state FSM sequences each instruction through FETCH/DECODE/EXEC/MEM/WB. Instruction and data memories are external, and the data port uses a req/ready handshake with unbounded wait states. Control signals come from the existing external control unit, which decodes `opcode`.

Parameters:
DATA_W, 64, datapath, register and PC width
NREGS, 32, register count; index NREGS-1 reads as zero (XZR)
PC_RESET, 0, PC value after reset

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
instr  in  32  instruction word from external IM, combinational on imem_addr
imem_addr  out  DATA_W  fetch address (= pc)
bus_reg2loc  in  1  1: second read port = instr[4:0] (Rt), 0: instr[20:16] (Rm)
bus_seu  in  2  immediate format select
bus_aluSrc  in  1  1: ALU B = immediate, 0: Rm/Rt
bus_aluOp  in  3  ALU operation
bus_memWr  in  1  store
bus_memToReg  in  1  load (writeback from memory)
bus_regWr  in  1  register write enable
beq  in  1  branch if zero
bne  in  1  branch if not zero
dmem_req  out  1  data memory request, held until accepted
dmem_we  out  1  1 = write
dmem_addr  out  DATA_W  data address
dmem_wdata  out  DATA_W  store data
dmem_rdata  in  DATA_W  load data, valid when dmem_ready
dmem_ready  in  1  completes the request in the same cycle
opcode  out  11  IR[31:21] to control unit
pc  out  DATA_W  current PC
state  out  3  FSM state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4

Behaviour:
- Reset (any state, including mid-MEM):
  - Next cycle: state=FETCH, pc=PC_RESET, IR=0, all registers=0.
  - dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0.
  - An outstanding memory request is abandoned without retry.
- FETCH (1 cycle): IR <= instr.
- DECODE (1 cycle):
  - A <= R[IR[9:5]].
  - B <= R[reg2loc ? IR[4:0] : IR[20:16]].
  - Latch all control inputs into a control register; later states use only the latched copies.
  - Immediate latched per bus_seu:
    - 00: zero-extend IR[21:10].
    - 01: sign-extend IR[20:12].
    - 10: sign-extend IR[25:0]<<2.
    - 11: sign-extend IR[23:5]<<2.
- EXEC (1 cycle): Y = A op (aluSrc ? imm : B); ALUOut <= Y; Z <= (Y==0).
  - 000 AND, 001 ORR, 010 ADD, 110 SUB, 111 pass-B; other codes give 0.
  - Arithmetic is modulo 2^DATA_W.
  - Next state is MEM if memWr|memToReg, otherwise WB.
- MEM:
  - dmem_req=1, dmem_we=memWr, dmem_addr=ALUOut, dmem_wdata=B; all held stable until dmem_ready.
  - On dmem_ready: MDR <= dmem_rdata (loads) and go to WB; dmem_req drops the next cycle.
  - memWr and memToReg both set: store has priority, MDR is not updated.
- WB (1 cycle):
  - If regWr and IR[4:0] != NREGS-1: R[IR[4:0]] <= memToReg ? MDR : ALUOut.
  - pc <= (beq&Z)|(bne&~Z) ? pc+imm : pc+4. Next state FETCH.
- Register indices >= NREGS read 0 and ignore writes.
- Latency: 4 cycles for non-memory instructions; 5 + wait cycles for memory instructions.
- dmem_ready outside MEM is ignored.

Optional Feature:
RUTA_PERF_CNT_EN:
- Defined: adds outputs cycle_count[31:0] and instr_count[31:0].
  - cycle_count increments every non-reset cycle.
  - instr_count increments on each WB.
  - stall_count[31:0] counts MEM cycles with dmem_ready=0.
  - All clear on rst and wrap at 2^32.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- ADD X1,X2,X3: X2=5, X3=7 (aluOp=010, aluSrc=0, regWr=1) -> after 4 cycles X1=12, pc=4, no dmem_req.
- LDUR X4,[X1,#8]: X1=0x100, dmem_ready held low 3 cycles, rdata=0xDEAD -> dmem_addr=0x108 stable for 4 req cycles, then X4=0xDEAD, pc+=4.
- STUR X4,[X1,#0]: X4=0xDEAD -> one dmem_req with we=1, addr=0x100, wdata=0xDEAD; no register changes.
- CBZ X5 with X5=0, imm19=3 (beq=1, seu=11) -> pc advances by 12; same instruction with X5=1 -> pc advances by 4.
- ADD X31,X2,X3 then read X31 -> write ignored, read returns 0.
- rst asserted in MEM with dmem_ready=0 -> next cycle state=FETCH, pc=PC_RESET, dmem_req=0, registers 0.
